// File: rtl/four_pa_scheduler.sv
// four_pa_scheduler: shares one downstream resource among four requesters.
// Requests and priorities are snapshotted in IDLE. ARB picks the requester with
// the largest aged effective priority; ties go to the highest index. GRANT
// holds a one-hot grant until done, request drop, or the MAX_HOLD limit.
// Losers are aged so that low-priority clients cannot starve.
//
// Handshake: a request is accepted when req is nonzero at a rising edge in
// IDLE. The grant is owned from the first cycle gnt_valid is high. It is given
// back by done=1, or by dropping req[gnt_idx], at any rising edge while
// gnt_valid is high. done is ignored at all other times.
//
// Parameter constraints: AGE_W <= N, so the aged sum fits in N+1 bits. MAX_HOLD >= 2.
module four_pa_scheduler #(
  parameter int N        = 8,
  parameter int AGE_W    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [N-1:0]         pri3,
  input  logic [N-1:0]         pri2,
  input  logic [N-1:0]         pri1,
  input  logic [N-1:0]         pri0,
  input  logic                 done,
  output logic [3:0]           gnt,
  output logic [1:0]           gnt_idx,
  output logic                 gnt_valid,
  output logic                 busy,
  output logic                 timeout,
  output logic [1:0]           dbg_state_o,
  output logic [4*AGE_W-1:0]   dbg_ages_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int EFF_W  = N + 1;

  state_t              state_q, state_d;
  logic [3:0]          req_s_q, req_s_d;
  logic [N-1:0]        pri_s_q [4];
  logic [N-1:0]        pri_s_d [4];
  logic [AGE_W-1:0]    age_q   [4];
  logic [AGE_W-1:0]    age_d   [4];
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          gnt_idx_q, gnt_idx_d;
  logic                timeout_q, timeout_d;

  logic [EFF_W-1:0]    eff [4];
  logic [EFF_W-1:0]    best_eff;
  logic [1:0]          win_idx;
  logic                hold_at_max;
  logic                req_cur;
  logic                release_now;

  // Aged max-select over the snapshot; >= lets a later (higher) index win ties.
  always_comb begin
    best_eff = '0;
    win_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      eff[i] = {1'b0, pri_s_q[i]} + EFF_W'(age_q[i]);
      if (req_s_q[i] && (eff[i] >= best_eff)) begin
        best_eff = eff[i];
        win_idx  = 2'(i);
      end
    end
  end

  // Release conditions for the current grant.
  always_comb begin
    hold_at_max = (hold_q == HOLD_W'(MAX_HOLD));
    req_cur     = req[gnt_idx_q];
    release_now = done || !req_cur || hold_at_max;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    req_s_d   = req_s_q;
    pri_s_d   = pri_s_q;
    age_d     = age_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          req_s_d    = req;
          pri_s_d[0] = pri0;
          pri_s_d[1] = pri1;
          pri_s_d[2] = pri2;
          pri_s_d[3] = pri3;
          state_d    = S_ARB;
        end
      end
      S_ARB: begin
        gnt_d     = 4'b0001 << win_idx;
        gnt_idx_d = win_idx;
        hold_d    = HOLD_W'(1);
        state_d   = S_GRANT;
        // Winner restarts at 0, waiting losers age (saturating), non-requesters reset.
        for (int i = 0; i < 4; i++) begin
          if (!req_s_q[i] || (win_idx == 2'(i))) begin
            age_d[i] = '0;
          end else if (age_q[i] != {AGE_W{1'b1}}) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d   = S_IDLE;
          gnt_d     = 4'b0000;
          hold_d    = '0;
          // Timeout only when the hold limit alone forced the release.
          timeout_d = hold_at_max && !done && req_cur;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset of every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_s_q   <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pri_s_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      req_s_q   <= req_s_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < 4; i++) begin
        pri_s_q[i] <= pri_s_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt         = gnt_q;
    gnt_idx     = gnt_idx_q;
    gnt_valid   = (state_q == S_GRANT);
    busy        = (state_q != S_IDLE);
    timeout     = timeout_q;
    dbg_state_o = state_q;
    dbg_ages_o  = '0;
    for (int i = 0; i < 4; i++) begin
      dbg_ages_o[i*AGE_W +: AGE_W] = age_q[i];
    end
  end

endmodule

// File: tb/tb_four_pa_scheduler.sv
// Bench for four_pa_scheduler: directed rounds and random rounds. A monitor
// pops the expected grant index whenever a new grant appears.
module tb_four_pa_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  pri3, pri2, pri1, pri0;
  logic        done;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        gnt_valid, busy, timeout;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_ages;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_q[$];
  logic [31:0] pri_q[$];

  logic [3:0]  m_age [4];

  four_pa_scheduler #(.N(8), .AGE_W(4), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .pri3(pri3), .pri2(pri2), .pri1(pri1), .pri0(pri0),
    .done(done), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .busy(busy), .timeout(timeout), .dbg_state_o(dbg_state), .dbg_ages_o(dbg_ages)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan from index 3 down, strictly greater replaces, so ties keep the higher index.
  function automatic logic [1:0] model_win(input logic [3:0] r, input logic [7:0] p3,
                                           input logic [7:0] p2, input logic [7:0] p1,
                                           input logic [7:0] p0);
    int e [4];
    int best;
    logic [1:0] w;
    e[3] = int'(p3) + int'(m_age[3]);
    e[2] = int'(p2) + int'(m_age[2]);
    e[1] = int'(p1) + int'(m_age[1]);
    e[0] = int'(p0) + int'(m_age[0]);
    best = -1;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i] && e[i] > best) begin
        best = e[i];
        w = 2'(i);
      end
    end
    return w;
  endfunction

  task automatic model_age_update(input logic [3:0] r, input logic [1:0] w);
    for (int i = 0; i < 4; i++) begin
      if (!r[i] || w == 2'(i)) m_age[i] = 4'd0;
      else if (m_age[i] != 4'd15) m_age[i] = m_age[i] + 4'd1;
    end
  endtask

  // Monitor: on each new grant, compare against the head of the expected queue.
  logic gv_prev = 1'b0;
  always @(negedge clk) begin
    logic [1:0]  e;
    logic [31:0] p;
    if (gnt_valid && !gv_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
      end else begin
        e = exp_q.pop_front();
        p = pri_q.pop_front();
        if (gnt_idx !== e) begin
          n_fail++;
          $display("FAIL gnt_idx: got %0d expected %0d pri3..0=%h %h %h %h", gnt_idx, e,
                   p[31:24], p[23:16], p[15:8], p[7:0]);
        end
        check("gnt_onehot", {28'd0, gnt}, {28'd0, 4'b0001 << e});
      end
    end
    gv_prev = gnt_valid;
  end

  // Wait for the grant that follows an accepted request; ARB must be visible first.
  task automatic wait_grant();
    int waited;
    @(negedge clk);
    check("arb_state", {30'd0, dbg_state}, 32'd1);
    check("arb_busy", {31'd0, busy}, 32'd1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!gnt_valid && waited < 8);
    check("grant_latency", waited, 32'd1);
  endtask

  // One full round: issue, wait for grant, hold, release with done.
  task automatic do_round(input logic [3:0] r, input logic [7:0] p3, input logic [7:0] p2,
                          input logic [7:0] p1, input logic [7:0] p0, input int hold,
                          input logic [1:0] exp_idx);
    logic [1:0] w;
    req = r; pri3 = p3; pri2 = p2; pri1 = p1; pri0 = p0;
    exp_q.push_back(exp_idx);
    pri_q.push_back({p3, p2, p1, p0});
    w = model_win(r, p3, p2, p1, p0);
    model_age_update(r, w);
    wait_grant();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("grant_held", {31'd0, gnt_valid}, 32'd1);
    end
    done = 1'b1;
    req  = 4'b0000;
    @(negedge clk);
    done = 1'b0;
    check("release_gnt", {28'd0, gnt}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd0);
    check("release_no_timeout", {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    logic [3:0] rr;
    logic [7:0] a, b, c, d;
    logic [1:0] w;
    int cnt;
    reset = 1'b1; req = 4'b0; done = 1'b0;
    pri3 = 8'h0; pri2 = 8'h0; pri1 = 8'h0; pri0 = 8'h0;
    for (int i = 0; i < 4; i++) m_age[i] = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_gnt_idx", {30'd0, gnt_idx}, 32'd0);
    check("rst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_ages", {16'd0, dbg_ages}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request, done three cycles after the grant.
    do_round(4'b0010, 8'h00, 8'h00, 8'h40, 8'h00, 3, 2'd1);
    // Tie between 2 and 1 at 8'h80 goes to index 2.
    do_round(4'b1111, 8'h10, 8'h80, 8'h80, 8'h20, 1, 2'd2);
    // Lone request clears every age.
    do_round(4'b0001, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    check("ages_cleared", {16'd0, dbg_ages}, 32'd0);

    // Aging rotation with equal top priorities.
    do_round(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2'd3);
    check("ages_round1", {16'd0, dbg_ages}, 32'h0111);
    do_round(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2'd2);
    check("ages_round2", {16'd0, dbg_ages}, 32'h1022);
    do_round(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2'd1);
    check("ages_round3", {16'd0, dbg_ages}, 32'h2103);
    do_round(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2'd0);
    check("ages_round4", {16'd0, dbg_ages}, 32'h3210);
    do_round(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2'd3);
    check("ages_round5", {16'd0, dbg_ages}, 32'h0321);

    // Timeout: requester 0 holds its request with no done.
    req = 4'b0001; pri3 = 8'h0; pri2 = 8'h0; pri1 = 8'h0; pri0 = 8'h33;
    exp_q.push_back(2'd0);
    pri_q.push_back({8'h0, 8'h0, 8'h0, 8'h33});
    model_age_update(4'b0001, 2'd0);
    wait_grant();
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!gnt_valid) break;
      cnt++;
    end
    check("hold_cycles", cnt, 32'd16);
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    check("timeout_gnt_clear", {28'd0, gnt}, 32'd0);
    exp_q.push_back(2'd0);
    pri_q.push_back({8'h0, 8'h0, 8'h0, 8'h33});
    model_age_update(4'b0001, 2'd0);
    @(negedge clk);
    check("timeout_one_cycle", {31'd0, timeout}, 32'd0);
    check("regrant_arb", {30'd0, dbg_state}, 32'd1);
    @(negedge clk);
    check("regrant_valid", {31'd0, gnt_valid}, 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("drop_release", {31'd0, gnt_valid}, 32'd0);
    check("drop_no_timeout", {31'd0, timeout}, 32'd0);

    // Random rounds against the reference model.
    for (int n = 0; n < 100; n++) begin
      rr = 4'($urandom_range(1, 15));
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
      w = model_win(rr, a, b, c, d);
      do_round(rr, a, b, c, d, $urandom_range(0, 4), w);
    end

    // Reset in the middle of a grant, with nonzero ages beforehand.
    req = 4'b1111; pri3 = 8'h55; pri2 = 8'h55; pri1 = 8'h55; pri0 = 8'h55;
    w = model_win(4'b1111, 8'h55, 8'h55, 8'h55, 8'h55);
    exp_q.push_back(w);
    pri_q.push_back(32'h55555555);
    model_age_update(4'b1111, w);
    wait_grant();
    reset = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("midrst_gnt", {28'd0, gnt}, 32'd0);
    check("midrst_gnt_idx", {30'd0, gnt_idx}, 32'd0);
    check("midrst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    check("midrst_ages", {16'd0, dbg_ages}, 32'd0);
    for (int i = 0; i < 4; i++) m_age[i] = 4'd0;
    reset = 1'b0;
    @(negedge clk);
    do_round(4'b0011, 8'h55, 8'h55, 8'h55, 8'h55, 1, 2'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/four_pa_scheduler.md
# four_pa_scheduler

Sequential four-requester resource scheduler built around the four-input max-priority compare used by the priority arbiter (max value wins, ties go to the highest index). It snapshots requests and per-requester priorities, arbitrates on aged effective priority, and issues a held one-hot grant until release or timeout. It shares a single downstream resource among four clients and prevents starvation by aging losers.

## Interface
- N, 8, requester priority width
- AGE_W, 4, age counter width; must satisfy AGE_W <= N
- MAX_HOLD, 16, maximum cycles a grant may be held; must be >= 2

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  4  request per requester, level; bit i = requester i
- pri3, pri2, pri1, pri0  in  N each  requester priorities, sampled with req
- done  in  1  release pulse from current grantee; ignored outside GRANT
- gnt  out  4  one-hot grant, registered
- gnt_idx  out  2  index of current grantee, valid while gnt_valid
- gnt_valid  out  1  high while in GRANT
- busy  out  1  high in ARB or GRANT
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD

## Operation
- FSM states: IDLE, ARB, GRANT. Reset state IDLE.
- IDLE: if |req, register snapshot of req (req_s) and pri0..pri3 (pri_s), go to ARB; else stay.
- ARB: per requester i, eff_i = {1'b0, pri_s_i} + age_i (N+1 bits, no overflow since AGE_W <= N). Only req_s bits participate. Winner = max eff; ties resolve to the highest index (3 > 2 > 1 > 0). Register gnt, gnt_idx, go to GRANT. req_s is nonzero by construction.
- Aging on ARB -> GRANT: winner age cleared to 0; other requesters with req_s=1 increment by 1, saturating at 2^AGE_W-1; requesters with req_s=0 cleared to 0.
- GRANT: hold counter starts at 1 on entry, increments each cycle. Release when any of: done=1; req[gnt_idx]=0; hold counter = MAX_HOLD. Release goes to IDLE (one idle gap cycle) with gnt cleared. If the release is caused only by the hold limit, i.e. done=0 and req[gnt_idx]=1, pulse timeout for the cycle after release.
- Simultaneous done and hold limit: treat as normal release with no timeout.
- No preemption. req/pri changes during ARB or GRANT do not affect the current decision.
- reset in any state, including mid-grant, forces IDLE and zeroes all outputs, ages, snapshot and hold counter at the next edge.

## Timing
- Reset values: gnt=4'b0000, gnt_idx=0, gnt_valid=0, busy=0, timeout=0; all ages 0.
- req sampled high at edge k in IDLE -> ARB after edge k -> gnt/gnt_valid high after edge k+1 (grant latency 2 cycles).
- Grant asserted for at most MAX_HOLD cycles. Release condition seen at edge m -> gnt=0 after edge m. Earliest next grant is after edge m+2.
- busy high in ARB and GRANT, low in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single request: req=4'b0010, pri1=8'h40, done pulsed 3 cycles after grant -> gnt=4'b0010, gnt_idx=1 two cycles after request; gnt low the cycle after done; timeout stays 0.
- Max select with tie: req=4'b1111, pri3=8'h10, pri2=8'h80, pri1=8'h80, pri0=8'h20 -> gnt_idx=2.
- Aging rotation: all four requesting continuously, all pri=8'hFF, done after each grant -> grant sequence 3, 2, 1, 0, 3. Ages after each round: (0,1,1,1), (1,0,2,2), (2,1,0,3), (3,2,1,0), listed as requesters 3,2,1,0.
- Timeout: MAX_HOLD=16, req=4'b0001 held, no done -> gnt high exactly 16 cycles; timeout pulses one cycle; then re-grant 2 cycles later.
- Reset mid-grant: assert reset during GRANT -> next cycle all outputs 0 and state IDLE; next arbitration with equal priorities picks the highest requesting index, since all ages are 0.
- Random: 100 rounds of random req (nonzero) and priorities against a reference model of aged max-select -> gnt_idx matches each round; report mismatches with all four priorities.
